// File: rtl/vga_arb.sv
// Write-port arbiter and clear sequencer for the VGA frame memory (CPU hold register, dumper req/gnt, full-screen clear).
// Latency: CPU write on mem one cycle after its hold-register capture; dumper grant/mem write one cycle after req is sampled.
// Backpressure: the CPU has none (a write into a full, non-issuing hold register is dropped and flagged sticky in cpu_ovf); dmp_req is held until dmp_gnt.
//
// Ports: clk/reset (async, active-low); cpu_w/cpu_x/cpu_y/cpu_d CPU pixel strobe;
// dmp_req/dmp_x/dmp_y/dmp_d/dmp_gnt dumper handshake; clr starts a clear, busy flags it;
// ovf_clr clears the sticky cpu_ovf; mem_we/mem_x/mem_y/mem_d registered memory write port.
module vga_arb #(
    parameter int XW        = 8,
    parameter int YW        = 8,
    parameter int DW        = 3,
    parameter int XMAX      = 159,
    parameter int YMAX      = 119,
    parameter int CLR_COLOR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_w,
    input  logic [XW-1:0] cpu_x,
    input  logic [YW-1:0] cpu_y,
    input  logic [DW-1:0] cpu_d,
    input  logic          dmp_req,
    input  logic [XW-1:0] dmp_x,
    input  logic [YW-1:0] dmp_y,
    input  logic [DW-1:0] dmp_d,
    output logic          dmp_gnt,
    input  logic          clr,
    input  logic          ovf_clr,
    output logic          busy,
    output logic          cpu_ovf,
    output logic          mem_we,
    output logic [XW-1:0] mem_x,
    output logic [YW-1:0] mem_y,
    output logic [DW-1:0] mem_d
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [XW-1:0] XLAST = XW'(XMAX);
    localparam logic [YW-1:0] YLAST = YW'(YMAX);
    localparam logic [DW-1:0] CCOL  = DW'(CLR_COLOR);

    state_t        state_q, state_d;
    logic          hold_vld_q, hold_vld_d;
    logic [XW-1:0] hold_x_q, hold_x_d;
    logic [YW-1:0] hold_y_q, hold_y_d;
    logic [DW-1:0] hold_d_q, hold_d_d;
    logic          last_dmp_q, last_dmp_d;   // 1 = dumper was granted last
    logic [XW-1:0] cnt_x_q, cnt_x_d;
    logic [YW-1:0] cnt_y_q, cnt_y_d;
    logic          ovf_q, ovf_d;
    logic          mem_we_q, mem_we_d;
    logic [XW-1:0] mem_x_q, mem_x_d;
    logic [YW-1:0] mem_y_q, mem_y_d;
    logic [DW-1:0] mem_d_q, mem_d_d;
    logic          dmp_gnt_q, dmp_gnt_d;

    logic cpu_iss, dmp_iss, cpu_ok, ovf_set;

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_x_d   = hold_x_q;
        hold_y_d   = hold_y_q;
        hold_d_d   = hold_d_q;
        last_dmp_d = last_dmp_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        mem_we_d   = 1'b0;
        mem_x_d    = mem_x_q;
        mem_y_d    = mem_y_q;
        mem_d_d    = mem_d_q;
        dmp_gnt_d  = 1'b0;
        cpu_iss    = 1'b0;
        dmp_iss    = 1'b0;
        ovf_set    = 1'b0;
        cpu_ok     = cpu_w && (cpu_x <= XLAST) && (cpu_y <= YLAST);

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_x_d = '0;
                    cnt_y_d = '0;
                end else if (hold_vld_q && dmp_req) begin
                    // Tie: whoever did not win last time goes now.
                    cpu_iss = last_dmp_q;
                    dmp_iss = !last_dmp_q;
                end else begin
                    cpu_iss = hold_vld_q;
                    dmp_iss = dmp_req;
                end
            end
            CLEAR: begin
                mem_we_d = 1'b1;
                mem_x_d  = cnt_x_q;
                mem_y_d  = cnt_y_q;
                mem_d_d  = CCOL;
                if (cnt_x_q == XLAST) begin
                    cnt_x_d = '0;
                    cnt_y_d = cnt_y_q + YW'(1);
                end else begin
                    cnt_x_d = cnt_x_q + XW'(1);
                end
                if (cnt_x_q == XLAST && cnt_y_q == YLAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cpu_iss) begin
            mem_we_d   = 1'b1;
            mem_x_d    = hold_x_q;
            mem_y_d    = hold_y_q;
            mem_d_d    = hold_d_q;
            last_dmp_d = 1'b0;
            hold_vld_d = 1'b0;
        end
        if (dmp_iss) begin
            mem_we_d   = 1'b1;
            mem_x_d    = dmp_x;
            mem_y_d    = dmp_y;
            mem_d_d    = dmp_d;
            dmp_gnt_d  = 1'b1;
            last_dmp_d = 1'b1;
        end

        // Capture runs in every state; the slot is free if empty or draining this edge.
        if (cpu_ok) begin
            if (!hold_vld_q || cpu_iss) begin
                hold_vld_d = 1'b1;
                hold_x_d   = cpu_x;
                hold_y_d   = cpu_y;
                hold_d_d   = cpu_d;
            end else begin
                ovf_set = 1'b1;
            end
        end
        // A new drop outranks a simultaneous clear request.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_vld_q <= 1'b0;
            hold_x_q   <= '0;
            hold_y_q   <= '0;
            hold_d_q   <= '0;
            last_dmp_q <= 1'b1;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            ovf_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_x_q    <= '0;
            mem_y_q    <= '0;
            mem_d_q    <= '0;
            dmp_gnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            hold_x_q   <= hold_x_d;
            hold_y_q   <= hold_y_d;
            hold_d_q   <= hold_d_d;
            last_dmp_q <= last_dmp_d;
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            ovf_q      <= ovf_d;
            mem_we_q   <= mem_we_d;
            mem_x_q    <= mem_x_d;
            mem_y_q    <= mem_y_d;
            mem_d_q    <= mem_d_d;
            dmp_gnt_q  <= dmp_gnt_d;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign cpu_ovf = ovf_q;
    assign mem_we  = mem_we_q;
    assign mem_x   = mem_x_q;
    assign mem_y   = mem_y_q;
    assign mem_d   = mem_d_q;
    assign dmp_gnt = dmp_gnt_q;

endmodule

// File: tb/tb_vga_arb.sv
// Bench for vga_arb with a small screen (4x2) so a whole clear fits in a few cycles.
// A reference model predicts every output each cycle; directed steps add literal checks.
module tb_vga_arb;

    localparam int XW = 8, YW = 8, DW = 3;
    localparam int XMAX = 3, YMAX = 1, CLR_C = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_w = 0, dmp_req = 0, clr = 0, ovf_clr = 0;
    logic [XW-1:0] cpu_x = 0, dmp_x = 0;
    logic [YW-1:0] cpu_y = 0, dmp_y = 0;
    logic [DW-1:0] cpu_d = 0, dmp_d = 0;
    logic          dmp_gnt, busy, cpu_ovf, mem_we;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic [DW-1:0] mem_d;

    int checks = 0;
    int errors = 0;

    vga_arb #(.XW(XW), .YW(YW), .DW(DW), .XMAX(XMAX), .YMAX(YMAX), .CLR_COLOR(CLR_C)) dut (
        .clk(clk), .reset(reset),
        .cpu_w(cpu_w), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_d(cpu_d),
        .dmp_req(dmp_req), .dmp_x(dmp_x), .dmp_y(dmp_y), .dmp_d(dmp_d), .dmp_gnt(dmp_gnt),
        .clr(clr), .ovf_clr(ovf_clr), .busy(busy), .cpu_ovf(cpu_ovf),
        .mem_we(mem_we), .mem_x(mem_x), .mem_y(mem_y), .mem_d(mem_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int x; int y; int d; } pix_t;
    pix_t clr_q[$];          // pixels still owed by a clear in progress
    bit   m_hold_full = 0;
    pix_t m_hold;
    bit   m_last_dmp = 1;
    int   e_x = 0, e_y = 0, e_d = 0;
    bit   e_we = 0, e_gnt = 0, e_busy = 0, e_ovf = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_q.delete();
            m_hold_full = 0; m_last_dmp = 1;
            e_x = 0; e_y = 0; e_d = 0;
            e_we = 0; e_gnt = 0; e_busy = 0; e_ovf = 0;
        end else begin
            bit cw, dw, drop;
            pix_t p;
            cw = 0; dw = 0; drop = 0;
            e_gnt = 0;
            if (clr_q.size() != 0) begin
                p = clr_q.pop_front();
                e_we = 1; e_x = p.x; e_y = p.y; e_d = p.d;
            end else if (clr) begin
                for (int yy = 0; yy <= YMAX; yy++)
                    for (int xx = 0; xx <= XMAX; xx++)
                        clr_q.push_back('{xx, yy, CLR_C});
                e_we = 0;
            end else begin
                if (m_hold_full && dmp_req) begin
                    cw = m_last_dmp;
                    dw = !m_last_dmp;
                end else begin
                    cw = m_hold_full;
                    dw = dmp_req;
                end
                e_we = cw | dw;
                if (cw) begin
                    e_x = m_hold.x; e_y = m_hold.y; e_d = m_hold.d;
                    m_hold_full = 0; m_last_dmp = 0;
                end
                if (dw) begin
                    e_x = dmp_x; e_y = dmp_y; e_d = dmp_d;
                    e_gnt = 1; m_last_dmp = 1;
                end
            end
            e_busy = (clr_q.size() != 0);
            if (cpu_w && cpu_x <= XMAX && cpu_y <= YMAX) begin
                if (!m_hold_full) begin
                    m_hold_full = 1;
                    m_hold = '{int'(cpu_x), int'(cpu_y), int'(cpu_d)};
                end else begin
                    drop = 1;
                end
            end
            if (drop) e_ovf = 1;
            else if (ovf_clr) e_ovf = 0;
        end
    end

    always @(negedge clk) begin
        chk("m_mem_we", mem_we, e_we);
        chk("m_dmp_gnt", dmp_gnt, e_gnt);
        chk("m_busy", busy, e_busy);
        chk("m_cpu_ovf", cpu_ovf, e_ovf);
        chk("m_mem_x", mem_x, e_x);
        chk("m_mem_y", mem_y, e_y);
        chk("m_mem_d", mem_d, e_d);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic w, input int x, input int y, input int d);
        cpu_w = w; cpu_x = XW'(x); cpu_y = YW'(y); cpu_d = DW'(d);
    endtask

    task automatic set_dmp(input logic r, input int x, input int y, input int d);
        dmp_req = r; dmp_x = XW'(x); dmp_y = YW'(y); dmp_d = DW'(d);
    endtask

    initial begin
        reset = 1'b0;
        // Reset held: inputs wiggle, outputs must stay quiet.
        set_cpu(1, 1, 1, 1); set_dmp(1, 2, 0, 3); clr = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_we", mem_we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gnt", dmp_gnt, 0);
            cpu_x = XW'(i); clr = ~clr;
        end
        set_cpu(0, 0, 0, 0); set_dmp(0, 0, 0, 0); clr = 0;
        #2 reset = 1'b1;
        tick();
        chk("rel_we", mem_we, 0);
        chk("rel_busy", busy, 0);

        // Single CPU write at the boundary column/row.
        set_cpu(1, 3, 1, 3);
        tick();
        set_cpu(0, 0, 0, 0);
        chk("cpu_lat_early_we", mem_we, 0);
        tick();
        chk("cpu_we", mem_we, 1);
        chk("cpu_x", mem_x, 3);
        chk("cpu_y", mem_y, 1);
        chk("cpu_d", mem_d, 3);
        chk("cpu_gnt", dmp_gnt, 0);
        tick();
        chk("cpu_we_off", mem_we, 0);
        chk("cpu_x_held", mem_x, 3);

        // Out-of-range CPU writes vanish without raising overflow.
        set_cpu(1, 4, 0, 1);
        tick();
        set_cpu(1, 0, 2, 1);
        tick();
        set_cpu(0, 0, 0, 0);
        tick();
        chk("oor_we", mem_we, 0);
        chk("oor_ovf", cpu_ovf, 0);

        // Lone dumper request.
        set_dmp(1, 1, 0, 6);
        tick();
        chk("dmp_gnt", dmp_gnt, 1);
        chk("dmp_we", mem_we, 1);
        chk("dmp_x", mem_x, 1);
        chk("dmp_d", mem_d, 6);
        set_dmp(0, 0, 0, 0);
        tick();
        chk("dmp_gnt_off", dmp_gnt, 0);

        // Contention: CPU, dumper, CPU, dumper, then the last CPU pixel.
        set_cpu(1, 0, 0, 1);
        tick();
        set_cpu(1, 1, 0, 2); set_dmp(1, 2, 1, 2);
        tick();
        chk("rr1_gnt", dmp_gnt, 0); chk("rr1_x", mem_x, 0); chk("rr1_d", mem_d, 1);
        set_cpu(0, 0, 0, 0);
        tick();
        chk("rr2_gnt", dmp_gnt, 1); chk("rr2_x", mem_x, 2); chk("rr2_y", mem_y, 1);
        set_dmp(1, 3, 1, 7); set_cpu(1, 2, 0, 3);
        tick();
        chk("rr3_gnt", dmp_gnt, 0); chk("rr3_x", mem_x, 1); chk("rr3_d", mem_d, 2);
        set_cpu(0, 0, 0, 0);
        tick();
        chk("rr4_gnt", dmp_gnt, 1); chk("rr4_x", mem_x, 3); chk("rr4_d", mem_d, 7);
        set_dmp(0, 0, 0, 0);
        tick();
        chk("rr5_gnt", dmp_gnt, 0); chk("rr5_x", mem_x, 2); chk("rr5_d", mem_d, 3);

        // Overflow: hold full, dumper wins the tie, second CPU write is lost.
        set_cpu(1, 0, 1, 4);
        tick();
        set_cpu(1, 1, 1, 5); set_dmp(1, 0, 0, 2);
        tick();
        chk("ovf_gnt", dmp_gnt, 1);
        chk("ovf_set", cpu_ovf, 1);
        set_cpu(0, 0, 0, 0); set_dmp(0, 0, 0, 0);
        tick();
        chk("ovf_kept_x", mem_x, 0); chk("ovf_kept_d", mem_d, 4);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("ovf_clr", cpu_ovf, 0);
        set_dmp(1, 2, 0, 1);
        tick();
        set_dmp(0, 0, 0, 0);
        tick();

        // Full clear with CPU/dumper traffic and a stray clr during it.
        clr = 1;
        tick();
        clr = 0;
        chk("clr_busy0", busy, 1);
        chk("clr_we0", mem_we, 0);
        set_dmp(1, 3, 0, 7);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) set_cpu(1, 1, 1, 4);
            if (i == 2) begin set_cpu(1, 2, 1, 6); ovf_clr = 1; end
            if (i == 3) begin set_cpu(0, 0, 0, 0); ovf_clr = 0; clr = 1; end
            if (i == 4) clr = 0;
            tick();
            chk("clr_we", mem_we, 1);
            chk("clr_x", mem_x, i % 4);
            chk("clr_y", mem_y, i / 4);
            chk("clr_d", mem_d, 5);
            chk("clr_gnt", dmp_gnt, 0);
            chk("clr_busy", busy, (i < 7) ? 1 : 0);
            if (i == 2) chk("clr_ovf_setwins", cpu_ovf, 1);
        end
        tick();
        chk("post_cpu_we", mem_we, 1); chk("post_cpu_x", mem_x, 1);
        chk("post_cpu_d", mem_d, 4); chk("post_cpu_gnt", dmp_gnt, 0);
        tick();
        chk("post_dmp_gnt", dmp_gnt, 1); chk("post_dmp_x", mem_x, 3); chk("post_dmp_d", mem_d, 7);
        set_dmp(0, 0, 0, 0);
        tick();

        // Reset in the middle of a clear, then a fresh clear from (0,0).
        clr = 1;
        tick();
        clr = 0;
        tick(); tick(); tick();
        chk("mid_x", mem_x, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_we", mem_we, 0); chk("arst_x", mem_x, 0); chk("arst_y", mem_y, 0);
        chk("arst_d", mem_d, 0); chk("arst_busy", busy, 0); chk("arst_ovf", cpu_ovf, 0);
        chk("arst_gnt", dmp_gnt, 0);
        tick(); tick();
        #2 reset = 1'b1;
        clr = 1;
        tick();
        clr = 0;
        tick();
        chk("re_we", mem_we, 1); chk("re_x", mem_x, 0); chk("re_y", mem_y, 0);
        chk("re_busy", busy, 1);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
